fetch_unit: RTL and testbench

Instruction fetch stage that consumes the pipeline hazard controls (`pc_stall`, `flush_fe`) and a branch target, and produces the instruction/PC pair for decode. It owns the PC register, issues requests to instruction memory over a request/ready + response-valid interface, and buffers up to two returned instructions. After a redirect it discards stale in-flight responses, so decode never sees a wrong-path instruction from the fetch side.

---
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage.
// Owns the PC, issues instruction-memory requests, buffers up to two returned
// instructions and presents a registered {inst, pc} pair to decode.
// Redirects (flush_fe) discard every response that was in flight at the time.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   pc_stall          hold PC, output register and request issue
//   flush_fe          redirect to branch_target, discard fetch contents
//   branch_target     redirect PC
//   imem_req/addr     request valid / address (= PC register)
//   imem_ready        memory accepts request this cycle
//   imem_rvalid/rdata in-order response valid / instruction
//   inst_out, pc_out  registered instruction and its PC
//   inst_valid        inst_out holds a real instruction (NOP otherwise)
module fetch_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter logic [31:0]     NOP      = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pc_stall,
   input  logic            flush_fe,
   input  logic [XLEN-1:0] branch_target,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     inst_out,
   output logic [XLEN-1:0] pc_out,
   output logic            inst_valid
);

   logic [XLEN-1:0] pc;
   logic [1:0]      outstanding;   // accepted requests whose response has not arrived
   logic [1:0]      drop_cnt;      // stale responses still to be discarded
   logic [1:0]      infl_cnt;      // live (non-stale) requests in flight
   logic [1:0]      bufcount;

   // Shift FIFOs: entry 0 is always the head.
   logic [XLEN-1:0] infl_pc  [2];
   logic [31:0]     buf_inst [2];
   logic [XLEN-1:0] buf_pc   [2];

   logic       accept, rsp_live, buf_empty, pop, bypass;
   logic       buf_wr, buf_rd, infl_rd;
   logic [2:0] credit;
   logic [1:0] bwpos, iwpos;

   always_comb begin
      accept    = imem_req & imem_ready;
      rsp_live  = imem_rvalid & (drop_cnt == 2'd0);
      buf_empty = (bufcount == 2'd0);
      pop       = !pc_stall & !flush_fe & (!buf_empty | rsp_live);
      // pop with an empty buffer can only come from a live response
      bypass    = pop & buf_empty;
      buf_rd    = pop & !buf_empty;
      buf_wr    = rsp_live & !bypass & !flush_fe;
      infl_rd   = rsp_live & !flush_fe;
      // outstanding + bufcount never exceeds 2, and pop implies one of them is nonzero
      credit    = {1'b0, outstanding} + {1'b0, bufcount} - {2'b00, pop};
      imem_req  = !rst & !flush_fe & !pc_stall & (credit < 3'd2);
      imem_addr = pc;
      bwpos     = bufcount - {1'b0, buf_rd};
      iwpos     = infl_cnt - {1'b0, infl_rd};
   end

   // Control and output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         infl_cnt    <= '0;
         bufcount    <= '0;
         inst_valid  <= 1'b0;
         inst_out    <= NOP;
         pc_out      <= '0;
      end else begin
         // accept is forced low during a flush, so this holds in every case
         outstanding <= outstanding + {1'b0, accept} - {1'b0, imem_rvalid};
         if (flush_fe) begin
            pc         <= branch_target;
            drop_cnt   <= outstanding - {1'b0, imem_rvalid};
            infl_cnt   <= '0;
            bufcount   <= '0;
            inst_valid <= 1'b0;
            inst_out   <= NOP;
         end else begin
            if (accept)
               pc <= pc + XLEN'(4);
            if (imem_rvalid && (drop_cnt != 2'd0))
               drop_cnt <= drop_cnt - 2'd1;
            infl_cnt <= infl_cnt + {1'b0, accept} - {1'b0, infl_rd};
            bufcount <= bufcount + {1'b0, buf_wr} - {1'b0, buf_rd};
            if (pop) begin
               inst_valid <= 1'b1;
               if (buf_empty) begin
                  inst_out <= imem_rdata;
                  pc_out   <= infl_pc[0];
               end else begin
                  inst_out <= buf_inst[0];
                  pc_out   <= buf_pc[0];
               end
            end else if (!pc_stall) begin
               inst_valid <= 1'b0;
               inst_out   <= NOP;
            end
         end
      end
   end

   // FIFO storage; occupancy counters above define which entries are meaningful.
   always_ff @(posedge clk) begin
      if (infl_rd)
         infl_pc[0] <= infl_pc[1];
      if (accept)
         infl_pc[iwpos[0]] <= pc;
      if (buf_rd) begin
         buf_inst[0] <= buf_inst[1];
         buf_pc[0]   <= buf_pc[1];
      end
      if (buf_wr) begin
         buf_inst[bwpos[0]] <= imem_rdata;
         buf_pc[bwpos[0]]   <= infl_pc[0];
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: behavioural instruction memory returning the
// address as data, directed hazard scenarios, and a scoreboard queue of
// expected PCs checked by an independent monitor process.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pc_stall = 1'b0;
   logic        flush_fe = 1'b0;
   logic [31:0] branch_target = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] inst_out;
   logic [31:0] pc_out;
   logic        inst_valid;

   always #5 clk = ~clk;

   fetch_unit #(
      .XLEN     (32),
      .RESET_PC (32'h0000_0000),
      .NOP      (NOP)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .pc_stall      (pc_stall),
      .flush_fe      (flush_fe),
      .branch_target (branch_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_rvalid   (imem_rvalid),
      .imem_rdata    (imem_rdata),
      .inst_out      (inst_out),
      .pc_out        (pc_out),
      .inst_valid    (inst_valid)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- instruction memory model ----------------
   int          lat = 1;
   bit          rand_ready = 1'b0;
   logic [31:0] pend_addr[$];
   int          pend_due[$];
   int          cyc = 0;

   initial begin
      logic        acc, rv, r;
      logic [31:0] a;
      imem_ready  = 1'b1;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
      forever begin
         @(negedge clk);
         acc = imem_req && imem_ready;
         a   = imem_addr;
         rv  = imem_rvalid;
         r   = rst;
         @(posedge clk);
         #1;
         cyc++;
         if (r) begin
            pend_addr.delete();
            pend_due.delete();
         end else begin
            if (rv) begin
               void'(pend_addr.pop_front());
               void'(pend_due.pop_front());
            end
            if (acc) begin
               pend_addr.push_back(a);
               pend_due.push_back(cyc + lat - 1);
            end
         end
         if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend_addr[0];
         end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
         end
         imem_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // ---------------- scoreboard monitor ----------------
   logic [31:0] exp_q[$];

   initial begin
      logic        upd;
      logic [31:0] e;
      forever begin
         @(posedge clk);
         upd = !pc_stall && !rst;   // output register could only change if not stalled
         @(negedge clk);
         if (upd && inst_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_pc_out", pc_out, e);
            chk("sb_inst_out", inst_out, e);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_reset(input bit check);
      @(posedge clk); #1;
      rst = 1'b1; pc_stall = 1'b0; flush_fe = 1'b0;
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      if (check) begin
         chk("rst_imem_req", imem_req, 1'b0);
         chk("rst_inst_valid", inst_valid, 1'b0);
         chk("rst_inst_out", inst_out, NOP);
         chk("rst_pc_out", pc_out, 32'h0);
         chk("rst_imem_addr", imem_addr, 32'h0);
      end
      @(posedge clk); #1;   // this edge is E0; cycle 0 follows
      rst = 1'b0;
   endtask

   task automatic push_seq(input logic [31:0] start, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
   endtask

   task automatic drain(input string name, input int budget);
      for (int i = 0; i < budget && exp_q.size() > 0; i++) @(negedge clk);
      chk(name, 32'(exp_q.size()), 32'h0);
   endtask

   initial begin
      bit seen;
      // ---- free run, 1-cycle memory ----
      lat = 1; rand_ready = 1'b0;
      do_reset(1'b1);
      push_seq(32'h0, 16);
      @(negedge clk);                       // cycle 0
      chk("run_c0_req", imem_req, 1'b1);
      chk("run_c0_addr", imem_addr, 32'h0);
      @(negedge clk);                       // cycle 1
      chk("run_c1_valid", inst_valid, 1'b0);
      chk("run_c1_addr", imem_addr, 32'h4);
      @(negedge clk);                       // cycle 2
      chk("run_c2_valid", inst_valid, 1'b1);
      chk("run_c2_pc", pc_out, 32'h0);
      drain("run_drain", 100);

      // ---- stall for 3 cycles while pc_out = 0x10 ----
      do_reset(1'b0);
      push_seq(32'h0, 10);
      repeat (6) @(posedge clk);
      #1 pc_stall = 1'b1;                   // cycles 6,7,8
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_pc_hold", pc_out, 32'h10);
         chk("stall_no_req", imem_req, 1'b0);
         @(posedge clk);
      end
      #1 pc_stall = 1'b0;
      @(negedge clk);                       // cycle 9: still held from stalled edge
      chk("stall_c9_pc", pc_out, 32'h10);
      chk("stall_c9_valid", inst_valid, 1'b1);
      @(negedge clk);                       // cycle 10
      chk("stall_c10_pc", pc_out, 32'h14);
      drain("stall_drain", 100);

      // ---- flush with two requests outstanding, 3-cycle memory ----
      lat = 3;
      do_reset(1'b0);
      repeat (5) @(posedge clk);
      #1 flush_fe = 1'b1; branch_target = 32'h100;
      @(negedge clk);                       // cycle 5
      chk("fl_outstanding", 32'(pend_addr.size()), 32'h2);
      chk("fl_rvalid", imem_rvalid, 1'b0);
      chk("fl_no_req", imem_req, 1'b0);
      @(posedge clk);
      #1 flush_fe = 1'b0;
      push_seq(32'h100, 4);
      @(negedge clk);                       // cycle 6
      chk("fl_invalid", inst_valid, 1'b0);
      chk("fl_nop", inst_out, NOP);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         if (imem_req) begin
            seen = 1'b1;
            chk("fl_new_addr", imem_addr, 32'h100);
         end else begin
            @(negedge clk);
         end
      end
      chk("fl_req_seen", 32'(seen), 32'h1);
      drain("fl_drain", 100);

      // ---- flush + stall coincident with a response, 3-cycle memory ----
      do_reset(1'b0);
      repeat (4) @(posedge clk);
      #1 flush_fe = 1'b1; pc_stall = 1'b1; branch_target = 32'h200;
      @(negedge clk);                       // cycle 4
      chk("fs_rvalid", imem_rvalid, 1'b1);
      chk("fs_outstanding", 32'(pend_addr.size()), 32'h2);
      @(posedge clk);
      #1 flush_fe = 1'b0; pc_stall = 1'b0;
      push_seq(32'h200, 4);
      @(negedge clk);                       // cycle 5
      chk("fs_invalid", inst_valid, 1'b0);
      chk("fs_nop", inst_out, NOP);
      chk("fs_req", imem_req, 1'b1);
      chk("fs_addr", imem_addr, 32'h200);
      drain("fs_drain", 100);

      // ---- random imem_ready ----
      lat = 1; rand_ready = 1'b1;
      do_reset(1'b0);
      push_seq(32'h0, 32);
      drain("rdy_drain", 600);
      rand_ready = 1'b0;

      // ---- PC wrap at 0xFFFF_FFFC ----
      do_reset(1'b0);
      repeat (3) @(posedge clk);
      #1 flush_fe = 1'b1; branch_target = 32'hFFFF_FFF8;
      @(posedge clk);
      #1 flush_fe = 1'b0;
      push_seq(32'hFFFF_FFF8, 5);
      drain("wrap_drain", 100);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
